// File: rtl/inst_fetch_unit_pkg.sv
// Shared types for the instruction-fetch path: instruction word, response
// record and the NOP returned for faulting fetches.
package typePack;
  typedef logic [31:0] instruction_t;

  localparam instruction_t NOP_INST = 32'h0000_0013;

  typedef struct packed {
    instruction_t inst;
    logic [31:0]  pc;
    logic         fault;
  } fetch_rsp_t;

  localparam fetch_rsp_t RSP_RESET = '{inst: NOP_INST, pc: 32'h0, fault: 1'b0};
endpackage

// File: rtl/inst_fetch_unit_rsp_fifo.sv
// DEPTH-entry response FIFO. The head is read straight from storage, so the
// response fields are registered and hold steady until popped.
module rsp_fifo
  import typePack::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  fetch_rsp_t       din,
  output logic [CNT_W-1:0] occ,
  output fetch_rsp_t       head
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_rsp_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = din;
        wr_d        = nxt(wr_q);
      end
      if (pop) rd_d = nxt(rd_q);
      // push and pop together leave the count alone, even when full
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= RSP_RESET;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  assign occ  = cnt_q;
  assign head = mem_q[rd_q];
endmodule

// File: rtl/inst_fetch_unit.sv
// Fetch responder: legality check, one-deep in-flight stage tagged with an
// epoch, credit-based request acceptance and an in-order response FIFO.
module inst_fetch_unit
  import typePack::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 2
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic              REQ_VALID,
  input  logic [31:0]       REQ_PC,
  output logic              REQ_READY,
  input  logic              FLUSH,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [31:0]       RSP_INST,
  output logic [31:0]       RSP_PC,
  output logic              RSP_FAULT,
  output logic              MEM_EN,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [31:0]       MEM_RDATA
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              inf_vld_q, inf_vld_d;
  logic [31:0]       inf_pc_q, inf_pc_d;
  logic              inf_fault_q, inf_fault_d;
  logic              inf_epoch_q, inf_epoch_d;
  logic              epoch_q, epoch_d;

  logic              legal, accept, push, pop;
  logic [CNT_W-1:0]  occ;
  logic [CNT_W:0]    credits;
  fetch_rsp_t        push_rsp, head;

  assign legal   = (REQ_PC[1:0] == 2'b00) && (REQ_PC[31:ADDR_W+2] == '0);
  assign credits = {1'b0, occ} + (CNT_W + 1)'(inf_vld_q);

  assign RSP_VALID = (occ != '0) && !FLUSH;
  assign pop       = RSP_VALID && RSP_READY;
  // a pop this cycle frees a slot, so a full unit can still take a request
  assign REQ_READY = RESET_N && !FLUSH &&
                     ((credits < (CNT_W + 1)'(DEPTH)) ||
                      ((credits == (CNT_W + 1)'(DEPTH)) && pop));
  assign accept    = REQ_VALID && REQ_READY;

  assign MEM_EN   = accept && legal;
  assign MEM_ADDR = MEM_EN ? REQ_PC[ADDR_W+1:2] : '0;

  // stale reads (older epoch) or reads landing on a flush edge never enter the FIFO
  assign push = inf_vld_q && (inf_epoch_q == epoch_q) && !FLUSH;

  always_comb begin
    push_rsp       = RSP_RESET;
    push_rsp.inst  = inf_fault_q ? NOP_INST : MEM_RDATA;
    push_rsp.pc    = inf_pc_q;
    push_rsp.fault = inf_fault_q;
  end

  always_comb begin
    epoch_d     = epoch_q ^ FLUSH;
    inf_vld_d   = accept;
    inf_pc_d    = inf_pc_q;
    inf_fault_d = inf_fault_q;
    inf_epoch_d = inf_epoch_q;
    if (accept) begin
      inf_pc_d    = REQ_PC;
      inf_fault_d = !legal;
      inf_epoch_d = epoch_q;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      inf_vld_q   <= 1'b0;
      inf_pc_q    <= '0;
      inf_fault_q <= 1'b0;
      inf_epoch_q <= 1'b0;
      epoch_q     <= 1'b0;
    end else begin
      inf_vld_q   <= inf_vld_d;
      inf_pc_q    <= inf_pc_d;
      inf_fault_q <= inf_fault_d;
      inf_epoch_q <= inf_epoch_d;
      epoch_q     <= epoch_d;
    end
  end

  rsp_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_rsp_fifo (
    .gclk   (CLOCK),
    .grst_n (RESET_N),
    .push   (push),
    .pop    (pop),
    .clear  (FLUSH),
    .din    (push_rsp),
    .occ    (occ),
    .head   (head)
  );

  assign RSP_INST  = head.inst;
  assign RSP_PC    = head.pc;
  assign RSP_FAULT = head.fault;
endmodule
